// File: rtl/seg_scan_capture.sv
// Captures the digits shown on a multiplexed 4-digit, 7-segment display by
// debouncing the scan and decoding each stable pattern. Define SEG_HEX_DECODE_EN to add the A..F decode.
module seg_scan_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [15:0] digits,
  output logic [3:0]  dvalid,
  output logic        frame_done,
  output logic        seg_err
);

  typedef enum logic {
    ST_WAIT,
    ST_LOCK
  } state_t;

  localparam logic [7:0] LAST_COUNT = 8'(STABLE_CYCLES - 1);

  logic [6:0]  seg_s1, seg_s2;
  logic [3:0]  an_s1, an_s2;
  logic [10:0] sample, prev;
  logic [7:0]  cnt;
  logic        same;
  logic        accept;
  state_t      state_q, state_d;

  logic [4:0]  dec;
  logic        dec_ok;
  logic [3:0]  dec_val;
  logic        one_hot;
  logic [1:0]  sel_idx;
  logic [3:0]  seen;
  logic [3:0]  seen_merge;

  // Decoded value in [3:0], legality flag in [4]; patterns are {g..a}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b1000000: decode = {1'b1, 4'd0};
      7'b1111001: decode = {1'b1, 4'd1};
      7'b0100100: decode = {1'b1, 4'd2};
      7'b0110000: decode = {1'b1, 4'd3};
      7'b0011001: decode = {1'b1, 4'd4};
      7'b0010010: decode = {1'b1, 4'd5};
      7'b0000010: decode = {1'b1, 4'd6};
      7'b1111000: decode = {1'b1, 4'd7};
      7'b0000000: decode = {1'b1, 4'd8};
      7'b0010000: decode = {1'b1, 4'd9};
`ifdef SEG_HEX_DECODE_EN
      7'b0001000: decode = {1'b1, 4'd10};
      7'b0000011: decode = {1'b1, 4'd11};
      7'b1000110: decode = {1'b1, 4'd12};
      7'b0100001: decode = {1'b1, 4'd13};
      7'b0000110: decode = {1'b1, 4'd14};
      7'b0001110: decode = {1'b1, 4'd15};
`endif
      default:    decode = 5'd0;
    endcase
  endfunction

  // NOTE: synchronizers and the previous-sample register reset to all ones
  // (the idle level of active-low lines) so release never looks like a capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      an_s1  <= '1;
      an_s2  <= '1;
      prev   <= '1;
      cnt    <= '0;
    end else begin
      seg_s1 <= seg_n;
      seg_s2 <= seg_s1;
      an_s1  <= an_n;
      an_s2  <= an_s1;
      prev   <= sample;
      if (!same)
        cnt <= '0;
      else if (cnt != 8'hff)
        cnt <= cnt + 8'd1;
    end
  end

  assign sample = {an_s2, seg_s2};
  assign same   = (sample == prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= ST_WAIT;
    else
      state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (same && cnt == LAST_COUNT) begin
          state_d = ST_LOCK;
          accept  = 1'b1;
        end
      end
      ST_LOCK: begin
        if (!same)
          state_d = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    sel_idx = 2'd0;
    one_hot = 1'b1;
    case (an_s2)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: one_hot = 1'b0;
    endcase
  end

  assign dec        = decode(seg_s2);
  assign dec_ok     = dec[4];
  assign dec_val    = dec[3:0];
  assign seen_merge = seen | ~an_s2;

  // Pulses default low each cycle; a completed frame clears seen on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits     <= '0;
      dvalid     <= '0;
      seen       <= '0;
      frame_done <= 1'b0;
      seg_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      seg_err    <= 1'b0;
      if (accept && an_s2 != 4'b1111) begin
        if (one_hot && dec_ok) begin
          digits[{sel_idx, 2'b00} +: 4] <= dec_val;
          dvalid[sel_idx]               <= 1'b1;
          if (seen_merge == 4'b1111) begin
            frame_done <= 1'b1;
            seen       <= '0;
          end else begin
            seen <= seen_merge;
          end
        end else begin
          seg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: directed scenarios plus random scan
// holds, compared each cycle against a run-length reference model of the inputs.
module tb_seg_scan_capture;

  localparam int S = 4;

`ifdef SEG_HEX_DECODE_EN
  localparam int N_LEGAL = 16;
`else
  localparam int N_LEGAL = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_n = '1;
  logic [3:0]  an_n = '1;
  logic [15:0] digits;
  logic [3:0]  dvalid;
  logic        frame_done;
  logic        seg_err;

  seg_scan_capture #(.STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .digits     (digits),
    .dvalid     (dvalid),
    .frame_done (frame_done),
    .seg_err    (seg_err)
  );

  always #5 clk = ~clk;

  // Display patterns {g..a} for values 0..15.
  logic [6:0] pat [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: inputs seen at each post-reset edge, and the outputs they imply.
  logic [10:0] hist [$];
  int          edge_no;
  logic [15:0] m_digits;
  logic [3:0]  m_dvalid, m_seen;
  logic        m_frame, m_err;
  int          err_cnt, frame_cnt;

  function automatic logic [10:0] get(input int e);
    return (e >= 1) ? hist[e-1] : 11'h7ff;
  endfunction

  // Accepted at edge e when the input seen at edge e-2 ended a run of exactly S+1 equal edges.
  function automatic bit accepts(input int e);
    logic [10:0] v;
    v = get(e - 2);
    for (int i = 1; i <= S; i++)
      if (get(e - 2 - i) != v) return 1'b0;
    return get(e - 3 - S) != v;
  endfunction

  task automatic model_reset();
    hist.delete();
    edge_no  = 0;
    m_digits = '0;
    m_dvalid = '0;
    m_seen   = '0;
    m_frame  = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_step();
    logic [10:0] v;
    logic [3:0]  a;
    int          found, k;
    m_frame = 1'b0;
    m_err   = 1'b0;
    if (accepts(edge_no)) begin
      v = get(edge_no - 2);
      a = v[10:7];
      if (a == 4'b1111) begin
        // blank scan slot: nothing to capture
      end else if ($countones(~a) == 1) begin
        found = -1;
        for (int i = 0; i < N_LEGAL; i++)
          if (pat[i] == v[6:0]) found = i;
        k = 0;
        for (int i = 0; i < 4; i++)
          if (!a[i]) k = i;
        if (found < 0) begin
          m_err = 1'b1;
        end else begin
          m_digits[k*4 +: 4] = found[3:0];
          m_dvalid[k]        = 1'b1;
          m_seen[k]          = 1'b1;
          if (m_seen == 4'b1111) begin
            m_frame = 1'b1;
            m_seen  = '0;
          end
        end
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  // Entered at a negedge: drive, take one posedge, check, return at the next negedge.
  task automatic cycle(input logic [6:0] s, input logic [3:0] a);
    seg_n = s;
    an_n  = a;
    @(posedge clk);
    edge_no++;
    hist.push_back({a, s});
    model_step();
    #1;
    check("digits", 32'(digits), 32'(m_digits));
    check("dvalid", 32'(dvalid), 32'(m_dvalid));
    check("frame_done", 32'(frame_done), 32'(m_frame));
    check("seg_err", 32'(seg_err), 32'(m_err));
    err_cnt   += int'(seg_err);
    frame_cnt += int'(frame_done);
    @(negedge clk);
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] a, input int n);
    for (int i = 0; i < n; i++) cycle(s, a);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_digits", 32'(digits), 32'd0);
    check("rst_dvalid", 32'(dvalid), 32'd0);
    check("rst_frame", 32'(frame_done), 32'd0);
    check("rst_err", 32'(seg_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_digits", 32'(digits), 32'd0);
    check("rst_hold_dvalid", 32'(dvalid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  int          e0, f0;
  logic        saw7;
  logic [3:0]  an_pick [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111};
  logic [6:0]  rs;
  logic [3:0]  ra;
  int          sel;

  initial begin
    err_cnt   = 0;
    frame_cnt = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Digit 0 shows "0": capture lands on the 7th edge after release.
    hold(pat[0], 4'b1110, 6);
    check("d0_not_yet", 32'(dvalid), 32'h0);
    cycle(pat[0], 4'b1110);
    check("d0_dvalid", 32'(dvalid), 32'h1);
    hold(pat[0], 4'b1110, 3);
    check("d0_digit", 32'(digits[3:0]), 32'h0);

    // Short glitch of "7" on digit 1 before settling on "1".
    saw7 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      cycle((i < 3) ? pat[7] : pat[1], 4'b1101);
      if (digits[7:4] == 4'd7) saw7 = 1'b1;
    end
    check("d1_value", 32'(digits[7:4]), 32'h1);
    check("d1_never7", 32'(saw7), 32'h0);
    check("d1_dvalid", 32'(dvalid), 32'h3);

    // Full frame in order 3,1,0,2 with values 9,2,5,8.
    do_reset();
    f0 = frame_cnt;
    hold(pat[9], 4'b0111, 8);
    hold(pat[2], 4'b1101, 8);
    hold(pat[5], 4'b1110, 8);
    check("frame_early", 32'(frame_cnt - f0), 32'd0);
    hold(pat[8], 4'b1011, 8);
    check("frame_digits", 32'(digits), 32'h9825);
    check("frame_pulses", 32'(frame_cnt - f0), 32'd1);

    // Two digits enabled at once.
    e0 = err_cnt;
    hold(pat[8], 4'b1010, 8);
    check("multi_err", 32'(err_cnt - e0), 32'd1);
    check("multi_digits", 32'(digits), 32'h9825);
    check("multi_dvalid", 32'(dvalid), 32'hf);

    // Hex "A" on digit 3.
    e0 = err_cnt;
    hold(pat[10], 4'b0111, 8);
`ifdef SEG_HEX_DECODE_EN
    check("hex_digit", 32'(digits[15:12]), 32'ha);
    check("hex_err", 32'(err_cnt - e0), 32'd0);
`else
    check("hex_digit", 32'(digits[15:12]), 32'h9);
    check("hex_err", 32'(err_cnt - e0), 32'd1);
`endif

    // Reset in the middle of a stable hold restarts the full latency.
    do_reset();
    hold(pat[3], 4'b1110, 2);
    do_reset();
    hold(pat[3], 4'b1110, 6);
    check("rst_mid_not_yet", 32'(dvalid), 32'h0);
    cycle(pat[3], 4'b1110);
    check("rst_mid_dvalid", 32'(dvalid), 32'h1);
    check("rst_mid_digit", 32'(digits[3:0]), 32'h3);

    // Random scan holds with occasional resets.
    for (int n = 0; n < 160; n++) begin
      if ($urandom_range(0, 24) == 0) do_reset();
      sel = int'($urandom_range(0, 9));
      ra  = (sel < 5) ? an_pick[sel] : ((sel < 9) ? an_pick[sel - 5] : 4'($urandom));
      sel = int'($urandom_range(0, 9));
      if (sel < 7)
        rs = pat[$urandom_range(0, 9)];
      else if (sel < 9)
        rs = pat[$urandom_range(10, 15)];
      else
        rs = 7'($urandom);
      hold(rs, ra, int'($urandom_range(1, 10)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
